// File: rtl/psram_qpi_responder.sv
// Dual-chip QPI PSRAM responder: decodes 35h/38h/EBh/F5h and backs them with a word memory.
// Lane 0 is DQ[3:0], lane 1 is DQ[7:4]; read data is registered one beat after a synchronous fetch.
module psram_qpi_responder #(
    parameter int P_AW   = 10,
    parameter int P_WAIT = 6
) (
    input  logic       arst_n,
    input  logic       i_clk,
    input  logic       i_csn,
    input  logic       i_sclk_en,
    input  logic [7:0] i_dq,
    output logic [7:0] o_dq,
    output logic [7:0] o_dq_oe,
    output logic       o_qpi,
    output logic       o_err
);

    // P_WAIT must be at least 1: the first fetch needs one beat before the drive edge.
    typedef enum logic [2:0] {
        ST_IDLE, ST_SPI_CMD, ST_QPI_CMD, ST_ADDR, ST_WR_DATA, ST_RD_WAIT, ST_RD_DATA, ST_SKIP
    } state_t;

    localparam logic [3:0] LP_WAIT_LAST = 4'(P_WAIT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [6:0]        r_sh;
    logic [P_AW-1:0]   r_addr;
    logic [P_AW-1:0]   r_ptr;
    logic [7:0]        r_hi;
    logic              r_is_wr;
    logic              r_qpi_set;
    logic              r_qpi_clr;
    logic [15:0]       r_rdw;
    logic [15:0]       r_mem [2**P_AW];

    state_t            w_st;
    state_t            w_state_nx;
    logic [3:0]        w_cnt_nx;
    logic [6:0]        w_sh_nx;
    logic [7:0]        w_spi_byte;
    logic [7:0]        w_qpi_byte;
    logic [P_AW-1:0]   w_addr_nx;
    logic [P_AW-1:0]   w_rd_addr;
    logic              w_beat;
    logic              w_is_wr_nx;
    logic              w_addr_shift;
    logic              w_ptr_load;
    logic              w_ptr_inc;
    logic              w_hi_load;
    logic              w_mem_we;
    logic              w_drive_hi;
    logic              w_drive_lo;
    logic              w_err_set;
    logic              w_set_pend;
    logic              w_clr_pend;

    assign w_beat     = !i_csn && i_sclk_en;
    assign w_spi_byte = {r_sh[6:0], i_dq[0]};
    assign w_qpi_byte = {r_sh[3:0], i_dq[3:0]};
    assign w_addr_nx  = P_AW'({r_addr, i_dq[3:0]});
    // The first beat of a transaction is consumed directly by the command state.
    assign w_st = (r_state == ST_IDLE) ? (o_qpi ? ST_QPI_CMD : ST_SPI_CMD) : r_state;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_sh_nx      = r_sh;
        w_is_wr_nx   = r_is_wr;
        w_rd_addr    = r_ptr;
        w_addr_shift = 1'b0;
        w_ptr_load   = 1'b0;
        w_ptr_inc    = 1'b0;
        w_hi_load    = 1'b0;
        w_mem_we     = 1'b0;
        w_drive_hi   = 1'b0;
        w_drive_lo   = 1'b0;
        w_err_set    = 1'b0;
        w_set_pend   = 1'b0;
        w_clr_pend   = 1'b0;
        if (i_csn) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 4'd0;
        end else if (i_sclk_en) begin
            w_cnt_nx = r_cnt + 4'd1;
            case (w_st)
                ST_SPI_CMD: begin
                    w_sh_nx    = w_spi_byte[6:0];
                    w_state_nx = ST_SPI_CMD;
                    if (r_cnt == 4'd7) begin
                        w_state_nx = ST_SKIP;
                        w_cnt_nx   = 4'd0;
                        w_set_pend = (w_spi_byte == 8'h35);
                    end
                end
                ST_QPI_CMD: begin
                    w_sh_nx    = {3'b000, i_dq[3:0]};
                    w_state_nx = ST_QPI_CMD;
                    if (r_cnt == 4'd1) begin
                        w_cnt_nx = 4'd0;
                        case (w_qpi_byte)
                            8'h38: begin w_state_nx = ST_ADDR; w_is_wr_nx = 1'b1; end
                            8'hEB: begin w_state_nx = ST_ADDR; w_is_wr_nx = 1'b0; end
                            8'hF5: begin w_state_nx = ST_SKIP; w_clr_pend = 1'b1; end
                            default: begin w_state_nx = ST_SKIP; w_err_set = 1'b1; end
                        endcase
                    end
                end
                ST_ADDR: begin
                    w_addr_shift = 1'b1;
                    w_rd_addr    = w_addr_nx;
                    if (r_cnt == 4'd5) begin
                        w_cnt_nx   = 4'd0;
                        w_ptr_load = 1'b1;
                        w_state_nx = r_is_wr ? ST_WR_DATA : ST_RD_WAIT;
                    end
                end
                ST_WR_DATA: begin
                    w_cnt_nx = {3'b000, ~r_cnt[0]};
                    if (!r_cnt[0]) begin
                        w_hi_load = 1'b1;
                    end else begin
                        w_mem_we  = 1'b1;
                        w_ptr_inc = 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == LP_WAIT_LAST) begin
                        w_drive_hi = 1'b1;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    w_cnt_nx = {3'b000, ~r_cnt[0]};
                    if (!r_cnt[0]) begin
                        // Low byte goes out now; prefetch the next word for the following high byte.
                        w_drive_lo = 1'b1;
                        w_ptr_inc  = 1'b1;
                        w_rd_addr  = r_ptr + {{(P_AW-1){1'b0}}, 1'b1};
                    end else begin
                        w_drive_hi = 1'b1;
                    end
                end
                default: w_cnt_nx = r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_sh      <= 7'd0;
            r_addr    <= '0;
            r_ptr     <= '0;
            r_hi      <= 8'd0;
            r_is_wr   <= 1'b0;
            r_qpi_set <= 1'b0;
            r_qpi_clr <= 1'b0;
            o_dq      <= 8'd0;
            o_dq_oe   <= 8'd0;
            o_qpi     <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_sh    <= w_sh_nx;
            r_is_wr <= w_is_wr_nx;
            if (w_addr_shift) r_addr <= w_addr_nx;
            if (w_ptr_load) r_ptr <= w_addr_nx;
            else if (w_ptr_inc) r_ptr <= r_ptr + {{(P_AW-1){1'b0}}, 1'b1};
            if (w_hi_load) r_hi <= i_dq;
            if (w_err_set) o_err <= 1'b1;
            if (i_csn) begin
                if (r_qpi_set) o_qpi <= 1'b1;
                if (r_qpi_clr) o_qpi <= 1'b0;
                r_qpi_set <= 1'b0;
                r_qpi_clr <= 1'b0;
                o_dq      <= 8'd0;
                o_dq_oe   <= 8'd0;
            end else begin
                if (w_set_pend) r_qpi_set <= 1'b1;
                if (w_clr_pend) r_qpi_clr <= 1'b1;
                if (w_drive_hi) begin
                    o_dq    <= r_rdw[15:8];
                    o_dq_oe <= 8'hFF;
                end else if (w_drive_lo) begin
                    o_dq    <= r_rdw[7:0];
                    o_dq_oe <= 8'hFF;
                end
            end
        end
    end

    // Memory and its read register are deliberately left without reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[r_ptr] <= {r_hi, i_dq};
        if (w_beat) r_rdw <= r_mem[w_rd_addr];
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder (P_AW=4 so the wrap case is reachable).
module tb_psram_qpi_responder;

    logic       arst_n;
    logic       i_clk;
    logic       i_csn;
    logic       i_sclk_en;
    logic [7:0] i_dq;
    logic [7:0] o_dq;
    logic [7:0] o_dq_oe;
    logic       o_qpi;
    logic       o_err;

    int n_chk = 0;
    int n_err = 0;

    psram_qpi_responder #(.P_AW(4), .P_WAIT(6)) u_dut (
        .arst_n    (arst_n),
        .i_clk     (i_clk),
        .i_csn     (i_csn),
        .i_sclk_en (i_sclk_en),
        .i_dq      (i_dq),
        .o_dq      (o_dq),
        .o_dq_oe   (o_dq_oe),
        .o_qpi     (o_qpi),
        .o_err     (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one beat; obs_* are the outputs present at this beat's sampling edge.
    task automatic beat(input logic [7:0] dq, output logic [7:0] obs_dq, output logic [7:0] obs_oe);
        @(negedge i_clk);
        obs_dq    = o_dq;
        obs_oe    = o_dq_oe;
        i_csn     = 1'b0;
        i_sclk_en = 1'b1;
        i_dq      = dq;
        @(posedge i_clk);
    endtask

    task automatic stall();
        @(negedge i_clk);
        i_csn     = 1'b0;
        i_sclk_en = 1'b0;
        @(posedge i_clk);
    endtask

    task automatic cs_high(input int n);
        @(negedge i_clk);
        i_csn     = 1'b1;
        i_sclk_en = 1'b0;
        i_dq      = 8'h00;
        repeat (n) @(posedge i_clk);
    endtask

    task automatic spi_byte(input string tag, input logic [7:0] b);
        logic [7:0] d, oe;
        for (int i = 7; i >= 0; i--) begin
            beat({3'b000, ~b[i], 3'b000, b[i]}, d, oe);
            chk({tag, " spi oe"}, {24'd0, oe}, 32'h0);
        end
    endtask

    task automatic qpi_cmd_addr(input logic [7:0] cmd, input logic [23:0] addr, input string tag);
        logic [7:0] d, oe;
        logic [31:0] w;
        w = {cmd, addr};
        for (int i = 0; i < 8; i++) begin
            beat({4'h0, w[31-4*i -: 4]}, d, oe);
            chk({tag, " hdr oe"}, {24'd0, oe}, 32'h0);
        end
    endtask

    task automatic qpi_write(input logic [23:0] addr, input logic [31:0] data, input int nbytes);
        logic [7:0] d, oe;
        qpi_cmd_addr(8'h38, addr, "wr");
        for (int i = 0; i < nbytes; i++) begin
            beat(data[31-8*i -: 8], d, oe);
            chk("wr data oe", {24'd0, oe}, 32'h0);
        end
        cs_high(1);
    endtask

    task automatic qpi_read(input string tag, input logic [23:0] addr, input logic [31:0] exp,
                            input int nbytes, input bit with_stall);
        logic [7:0] d, oe;
        qpi_cmd_addr(8'hEB, addr, tag);
        for (int i = 0; i < 6; i++) begin
            if (with_stall) stall();
            beat(8'h00, d, oe);
            chk({tag, " dummy oe"}, {24'd0, oe}, 32'h0);
        end
        for (int i = 0; i < nbytes; i++) begin
            if (with_stall) stall();
            beat(8'h00, d, oe);
            chk({tag, " data"}, {24'd0, d}, {24'd0, exp[31-8*i -: 8]});
            chk({tag, " data oe"}, {24'd0, oe}, 32'hFF);
        end
        cs_high(1);
        @(negedge i_clk);
        chk({tag, " oe after cs"}, {24'd0, o_dq_oe}, 32'h0);
    endtask

    task automatic enter_qpi(input string tag);
        spi_byte(tag, 8'h35);
        @(negedge i_clk);
        chk({tag, " qpi pending"}, {31'd0, o_qpi}, 32'h0);
        cs_high(1);
        @(negedge i_clk);
        chk({tag, " qpi set"}, {31'd0, o_qpi}, 32'h1);
    endtask

    initial begin
        logic [7:0] d, oe;
        arst_n    = 1'b0;
        i_csn     = 1'b1;
        i_sclk_en = 1'b0;
        i_dq      = 8'h00;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst o_dq", {24'd0, o_dq}, 32'h0);
        chk("rst o_dq_oe", {24'd0, o_dq_oe}, 32'h0);
        chk("rst o_qpi", {31'd0, o_qpi}, 32'h0);
        chk("rst o_err", {31'd0, o_err}, 32'h0);
        arst_n = 1'b1;
        cs_high(2);

        enter_qpi("entry");
        chk("entry err", {31'd0, o_err}, 32'h0);

        qpi_write(24'h000010, 32'hA55A_0000, 2);
        qpi_read("rd10", 24'h000010, 32'hA55A_0000, 2, 1'b0);

        qpi_write(24'h00000F, 32'h1111_2222, 4);
        qpi_read("wrap", 24'h00000F, 32'h1111_2222, 4, 1'b1);

        qpi_write(24'h000020, 32'h1234_0000, 2);
        qpi_write(24'h000020, 32'hAB00_0000, 1);
        qpi_read("abort", 24'h000020, 32'h1234_0000, 2, 1'b0);

        beat(8'h07, d, oe);
        beat(8'h07, d, oe);
        for (int i = 0; i < 16; i++) begin
            beat(8'h00, d, oe);
            chk("ill oe", {24'd0, oe}, 32'h0);
        end
        cs_high(1);
        @(negedge i_clk);
        chk("ill err", {31'd0, o_err}, 32'h1);
        chk("ill qpi kept", {31'd0, o_qpi}, 32'h1);

        beat(8'h0F, d, oe);
        beat(8'h05, d, oe);
        @(negedge i_clk);
        chk("exit pending", {31'd0, o_qpi}, 32'h1);
        cs_high(1);
        @(negedge i_clk);
        chk("exit qpi", {31'd0, o_qpi}, 32'h0);

        spi_byte("spi_eb", 8'hEB);
        for (int i = 0; i < 12; i++) begin
            beat(8'h00, d, oe);
            chk("spi_eb oe", {24'd0, oe}, 32'h0);
        end
        cs_high(1);
        @(negedge i_clk);
        chk("spi_eb qpi", {31'd0, o_qpi}, 32'h0);
        chk("err sticky", {31'd0, o_err}, 32'h1);

        enter_qpi("reentry");
        qpi_cmd_addr(8'hEB, 24'h000010, "rst_rd");
        for (int i = 0; i < 6; i++) beat(8'h00, d, oe);
        @(negedge i_clk);
        chk("rst_rd hi", {24'd0, o_dq}, 32'h12);
        chk("rst_rd oe", {24'd0, o_dq_oe}, 32'hFF);
        i_csn     = 1'b0;
        i_sclk_en = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        chk("async oe", {24'd0, o_dq_oe}, 32'h0);
        chk("async qpi", {31'd0, o_qpi}, 32'h0);
        chk("async err", {31'd0, o_err}, 32'h0);
        i_csn     = 1'b1;
        i_sclk_en = 1'b0;
        @(negedge i_clk);
        arst_n = 1'b1;
        cs_high(1);

        enter_qpi("post_rst");
        qpi_read("post_rst", 24'h00000F, 32'h1111_0000, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/psram_qpi_responder.md
# psram_qpi_responder

Synthesizable responder for the dual-chip QPI PSRAM bus that our PSRAM controller drives. It decodes SPI-mode QPI entry (35h), QPI write (38h), QPI fast read (EBh) and QPI exit (F5h), and backs them with an internal word-wide memory. It sits on the far side of the 8-bit DQ bus, either in the simulation bench as a PSRAM model or in FPGA fabric for controller loopback tests without the external chips. Each chip is modeled as one nibble lane: lane 0 is DQ[3:0], lane 1 is DQ[7:4].

## Interface
- P_AW, 10: memory word-address width; depth is 2**P_AW 16-bit words.
- P_WAIT, 6: read dummy beats between the last address nibble and the first data beat.
- arst_n  in  1  asynchronous, active-low reset
- i_clk  in  1  clock; the bus SCLK is this clock gated
- i_csn  in  1  chip select, active-low
- i_sclk_en  in  1  high when SCLK is toggling; qualifies beats
- i_dq  in  8  sampled DQ bus
- o_dq  out  8  driven read data
- o_dq_oe  out  8  per-bit output enable for o_dq
- o_qpi  out  1  1 = QPI mode is active
- o_err  out  1  sticky flag for an unknown QPI command; cleared only by reset

## Operation
- A beat is an i_clk rising edge with i_csn=0 and i_sclk_en=1. All sampling happens on i_clk rising edges.
- States:
  - IDLE
  - SPI_CMD
  - QPI_CMD
  - ADDR
  - WR_DATA
  - RD_WAIT
  - RD_DATA
  - SKIP
- Beat counter: 4 bits.
- IDLE:
  - On the first beat, go to SPI_CMD if o_qpi=0, or QPI_CMD if o_qpi=1.
  - The first beat is also processed as data by the destination state.
- SPI_CMD:
  - Shift i_dq[0] in MSB first for 8 beats. i_dq[4] is ignored.
  - If the byte is 35h, set o_qpi when i_csn rises.
  - After the 8th beat, go to SKIP.
- QPI_CMD:
  - Two beats, high nibble then low nibble, taken from i_dq[3:0].
  - 38h or EBh: go to ADDR.
  - F5h: clear o_qpi when i_csn rises, then SKIP.
  - Any other value: set o_err, then SKIP.
- ADDR:
  - Six beats, A[23:20] first down to A[3:0], from i_dq[3:0].
  - Word pointer = A[P_AW-1:0]. Upper address bits are ignored.
- WR_DATA (after 38h):
  - Even beat captures hi = i_dq[7:0].
  - Odd beat writes mem[ptr] = {hi, i_dq[7:0]} and increments ptr.
  - Bursts continue until i_csn rises.
- RD_WAIT (after EBh): P_WAIT beats with o_dq_oe=0, then RD_DATA.
- RD_DATA:
  - Drive mem[ptr][15:8], then mem[ptr][7:0], with o_dq_oe=FFh.
  - After the low byte, increment ptr and repeat.
- SKIP: ignore the bus until i_csn rises.
- i_csn rising from any state:
  - Next state is IDLE.
  - o_dq_oe goes to 00h.
  - Pending mode changes are applied.
  - An uncompleted write word (hi captured only) is discarded.
- ptr wrap: 2**P_AW-1 increments to 0.
- Memory is not reset. Contents after power-up are undefined (X in simulation).

## Timing
- Reset values:
  - o_dq=00h
  - o_dq_oe=00h
  - o_qpi=0
  - o_err=0
  - state=IDLE
- Reset mid-transaction has immediate effect: o_dq_oe is forced to 0 asynchronously.
- Read latency, with beat 0 = the first command nibble:
  - Beats 0-1: command.
  - Beats 2-7: address.
  - Beats 8..7+P_WAIT: dummy.
  - o_dq/o_dq_oe are registered. They update on the edge of beat 7+P_WAIT.
  - The high byte is therefore stable at the sampling edge of beat 8+P_WAIT (beat 14 at the default). The low byte is stable at beat 9+P_WAIT.
- The read-data memory access is a synchronous read, issued one beat ahead so that it fits the registered drive.
- Write: the memory update is visible to a read issued in the next transaction. The minimum i_csn-high gap is 1 cycle.
- o_dq_oe falls on the first i_clk edge that samples i_csn=1.
- Beats with i_sclk_en=0 and i_csn=0 are stall cycles: state and counters hold.

## Test plan
- Mode entry: SPI beats 0,0,1,1,0,1,0,1 (35h), then i_csn high -> o_qpi=1 one cycle later; o_err=0.
- Write then read, in QPI:
  - Write: 38h, address 000010h, data A5h then 5Ah.
  - Read: EBh, address 000010h.
  - Required: o_dq=A5h at beat 14 and 5Ah at beat 15; o_dq_oe=FFh on both beats, 00h on every beat before 14.
- Burst and wrap, P_AW=4:
  - Write words 1111h/2222h starting at address 00000Fh (wraps to word 0).
  - Required: a read at 0Fh returns 11h, 11h, 22h, 22h.
- Abort: write 38h, address 000020h, high byte only, then i_csn high -> a read of word 20h returns its prior value (1234h preloaded).
- Illegal command and exit:
  - QPI command 77h -> o_err=1, bus never driven.
  - F5h -> o_qpi=0.
  - A subsequent EBh is then decoded as SPI bits, no drive.
- Reset mid-read: assert arst_n at beat 14 -> o_dq_oe=00h and o_qpi=0 without waiting for a clock edge; after release, state is IDLE.
